// File: rtl/cp0_pkg.sv
// Shared CP0 constants, register field layout and packing helpers.
package cp0_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned HW_INT_W = 6;
    localparam int unsigned SW_INT_W = 2;
    localparam int unsigned IM_W     = HW_INT_W + SW_INT_W;
    localparam int unsigned CODE_W   = 5;

    // CP0 register numbers (rd field of mtc0/mfc0)
    localparam logic [REG_W-1:0] CP0_SR    = 5'd12;
    localparam logic [REG_W-1:0] CP0_CAUSE = 5'd13;
    localparam logic [REG_W-1:0] CP0_EPC   = 5'd14;
    localparam logic [REG_W-1:0] CP0_PRID  = 5'd15;

    // Status register bit positions
    localparam int unsigned SR_IE_BIT  = 0;
    localparam int unsigned SR_EXL_BIT = 1;
    localparam int unsigned SR_IM_LO   = 8;

    // Cause register bit positions
    localparam int unsigned CAUSE_CODE_LO  = 2;
    localparam int unsigned CAUSE_IP_LO    = 8;
    localparam int unsigned CAUSE_IP_HW_LO = 10;

    // Exception vector, also used by pc_module
    localparam logic [XLEN-1:0] EXC_VECTOR   = 32'h0000_0800;
    localparam logic [XLEN-1:0] PRID_DEFAULT = 32'h0001_8000;

    typedef enum logic [CODE_W-1:0] {
        EXC_INT = 5'd0,
        EXC_SYS = 5'd8,
        EXC_RI  = 5'd10,
        EXC_OV  = 5'd12
    } exc_code_e;

    // Writable Status state; all other SR bits read as zero
    typedef struct packed {
        logic [IM_W-1:0] im;
        logic            exl;
        logic            ie;
    } sr_t;

    // Stored Cause state; IP[15:10] comes live from the synchronizer
    typedef struct packed {
        logic [SW_INT_W-1:0] ip_sw;
        exc_code_e           code;
    } cause_t;

    // Expand stored SR fields to the architectural 32-bit view
    function automatic logic [XLEN-1:0] sr_word(input sr_t sr);
        logic [XLEN-1:0] w;
        w                       = '0;
        w[SR_IM_LO +: IM_W]     = sr.im;
        w[SR_EXL_BIT]           = sr.exl;
        w[SR_IE_BIT]            = sr.ie;
        return w;
    endfunction

    // Expand stored Cause fields plus live hardware IP bits to 32 bits
    function automatic logic [XLEN-1:0] cause_word(input cause_t c,
                                                   input logic [HW_INT_W-1:0] ip_hw);
        logic [XLEN-1:0] w;
        w                                = '0;
        w[CAUSE_IP_HW_LO +: HW_INT_W]    = ip_hw;
        w[CAUSE_IP_LO +: SW_INT_W]       = c.ip_sw;
        w[CAUSE_CODE_LO +: CODE_W]       = c.code;
        return w;
    endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// Two-flop synchronizer for the asynchronous hardware interrupt lines.
module cp0_int_sync #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;

    // First stage may go metastable; second stage presents a settled value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception controller: SR/Cause/EPC/PrID, exception detection,
// interrupt masking, mtc0/mfc0 access and eret handling.
module cp0_exc_unit
    import cp0_pkg::*;
#(
    parameter logic [XLEN-1:0] PRID = PRID_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [XLEN-1:0]     pc,
    input  logic                IsCOP0,
    input  logic                IsEret,
    input  logic                IsMtc0,
    input  logic [REG_W-1:0]    cp0_sel,
    input  logic [XLEN-1:0]     wdata,
    output logic [XLEN-1:0]     rdata,
    input  logic                exc_ri,
    input  logic                exc_ov,
    input  logic                exc_sys,
    input  logic [HW_INT_W-1:0] hw_int,
    output logic                HasExp,
    output logic [XLEN-1:0]     epc
);

    logic [HW_INT_W-1:0] ip_hw;

    sr_t             sr_q,    sr_d;
    cause_t          cause_q, cause_d;
    logic [XLEN-1:0] epc_q,   epc_d;

    logic            exc_sync_c;
    logic            int_req_c;
    logic            take_c;
    exc_code_e       code_c;

    cp0_int_sync #(
        .W (HW_INT_W)
    ) u_int_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (hw_int),
        .q     (ip_hw)
    );

    // Exception detection and ExcCode priority (RI > Ov > Sys > Int)
    always_comb begin
        exc_sync_c = exc_ri | exc_ov | exc_sys;
        int_req_c  = (|({ip_hw, cause_q.ip_sw} & sr_q.im)) & sr_q.ie & ~sr_q.exl;
        take_c     = exc_sync_c | int_req_c;
        code_c     = EXC_INT;
        if (exc_ri) begin
            code_c = EXC_RI;
        end else if (exc_ov) begin
            code_c = EXC_OV;
        end else if (exc_sys) begin
            code_c = EXC_SYS;
        end
    end

    // Redirect request to pc_module; held low throughout reset
    assign HasExp = rst_n & take_c;
    assign epc    = epc_q;

    // Next register state: exception entry beats mtc0 and eret
    always_comb begin
        sr_d    = sr_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        if (take_c) begin
            epc_d        = pc;
            cause_d.code = code_c;
            sr_d.exl     = 1'b1;
        end else begin
            if (IsCOP0 && IsMtc0) begin
                case (cp0_sel)
                    CP0_SR: begin
                        sr_d.im  = wdata[SR_IM_LO +: IM_W];
                        sr_d.exl = wdata[SR_EXL_BIT];
                        sr_d.ie  = wdata[SR_IE_BIT];
                    end
                    CP0_CAUSE: cause_d.ip_sw = wdata[CAUSE_IP_LO +: SW_INT_W];
                    CP0_EPC:   epc_d         = wdata;
                    default:   ;
                endcase
            end
            if (IsCOP0 && IsEret) begin
                sr_d.exl = 1'b0;
            end
        end
    end

    // CP0 state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q    <= '0;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            sr_q    <= sr_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    // mfc0 read mux; shows pre-edge state with no write bypass
    always_comb begin
        rdata = '0;
        case (cp0_sel)
            CP0_SR:    rdata = sr_word(sr_q);
            CP0_CAUSE: rdata = cause_word(cause_q, ip_hw);
            CP0_EPC:   rdata = epc_q;
            CP0_PRID:  rdata = PRID;
            default:   rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Bench for cp0_exc_unit: directed scenarios plus randomized traffic
// checked against an architectural model of the CP0 registers.
module tb_cp0_exc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        IsCOP0, IsEret, IsMtc0;
    logic [4:0]  cp0_sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exc_ri, exc_ov, exc_sys;
    logic [5:0]  hw_int;
    logic        HasExp;
    logic [31:0] epc;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Architectural model state
    logic [7:0]  m_im;
    logic        m_exl, m_ie;
    logic [1:0]  m_ip_sw;
    logic [4:0]  m_code;
    logic [31:0] m_epc;
    logic [5:0]  m_hwq[$];   // hw_int samples still travelling to Cause.IP

    cp0_exc_unit #(.PRID(32'h0001_8000)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pc      (pc),
        .IsCOP0  (IsCOP0),
        .IsEret  (IsEret),
        .IsMtc0  (IsMtc0),
        .cp0_sel (cp0_sel),
        .wdata   (wdata),
        .rdata   (rdata),
        .exc_ri  (exc_ri),
        .exc_ov  (exc_ov),
        .exc_sys (exc_sys),
        .hw_int  (hw_int),
        .HasExp  (HasExp),
        .epc     (epc)
    );

    always #5 clk = ~clk;

    function automatic logic m_int_req();
        return (|({m_hwq[0], m_ip_sw} & m_im)) && m_ie && !m_exl;
    endfunction

    function automatic logic m_has_exp();
        return exc_ri || exc_ov || exc_sys || m_int_req();
    endfunction

    function automatic logic [4:0] m_win_code();
        if (exc_ri)  return 5'd10;
        if (exc_ov)  return 5'd12;
        if (exc_sys) return 5'd8;
        return 5'd0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] sel);
        case (sel)
            5'd12:   return {16'h0, m_im, 6'h0, m_exl, m_ie};
            5'd13:   return {16'h0, m_hwq[0], m_ip_sw, 1'b0, m_code, 2'b00};
            5'd14:   return m_epc;
            5'd15:   return 32'h0001_8000;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_im = '0; m_exl = 1'b0; m_ie = 1'b0; m_ip_sw = '0; m_code = '0; m_epc = '0;
        m_hwq = '{6'h0, 6'h0};
    endtask

    // One rising edge of the architectural model using the current inputs
    task automatic m_edge();
        if (m_has_exp()) begin
            m_epc  = pc;
            m_code = m_win_code();
            m_exl  = 1'b1;
        end else begin
            if (IsCOP0 && IsMtc0) begin
                case (cp0_sel)
                    5'd12: begin m_im = wdata[15:8]; m_exl = wdata[1]; m_ie = wdata[0]; end
                    5'd13: m_ip_sw = wdata[9:8];
                    5'd14: m_epc = wdata;
                    default: ;
                endcase
            end
            if (IsCOP0 && IsEret) m_exl = 1'b0;
        end
        m_hwq.push_back(hw_int);
        void'(m_hwq.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        IsCOP0 = 1'b0; IsEret = 1'b0; IsMtc0 = 1'b0;
        exc_ri = 1'b0; exc_ov = 1'b0; exc_sys = 1'b0;
        wdata  = '0;
    endtask

    task automatic do_mtc0(input logic [4:0] sel, input logic [31:0] val);
        IsCOP0 = 1'b1; IsMtc0 = 1'b1; cp0_sel = sel; wdata = val;
        tick();
        idle();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; hw_int = 6'h3F; exc_sys = 1'b1;
        #1;
        n_cmp++; if (HasExp !== 1'b0) begin n_err++; $display("FAIL reset_hasexp: got %b want 0", HasExp); end
        n_cmp++; if (epc !== 32'h0) begin n_err++; $display("FAIL reset_epc: got %h want 0", epc); end
        @(posedge clk); @(negedge clk);
        #1;
        n_cmp++; if (HasExp !== 1'b0) begin n_err++; $display("FAIL reset_hasexp_held: got %b want 0", HasExp); end
        @(negedge clk);
        m_reset();
        exc_sys = 1'b0; hw_int = 6'h0; rst_n = 1'b1;
        cp0_sel = 5'd12; #1;
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_sr: got %h want 0", rdata); end
        cp0_sel = 5'd15; #1;
        n_cmp++; if (rdata !== 32'h0001_8000) begin n_err++; $display("FAIL reset_prid: got %h want 00018000", rdata); end
        cp0_sel = 5'd13; #1;
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_cause: got %h want 0", rdata); end
        tick();
    endtask

    task automatic test_syscall();
        pc = 32'h0000_0040; exc_sys = 1'b1; cp0_sel = 5'd0; #1;
        n_cmp++; if (HasExp !== 1'b1) begin n_err++; $display("FAIL sys_hasexp: got %b want 1", HasExp); end
        tick();
        idle();
        cp0_sel = 5'd14; #1;
        n_cmp++; if (rdata !== 32'h40 || epc !== 32'h40) begin n_err++; $display("FAIL sys_epc: got %h/%h want 40", rdata, epc); end
        cp0_sel = 5'd13; #1;
        n_cmp++; if (rdata[6:2] !== 5'd8) begin n_err++; $display("FAIL sys_code: got %0d want 8", rdata[6:2]); end
        cp0_sel = 5'd12; #1;
        n_cmp++; if (rdata[1] !== 1'b1) begin n_err++; $display("FAIL sys_exl: got %b want 1", rdata[1]); end
        tick();
    endtask

    task automatic test_interrupt();
        do_mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'h01; pc = 32'h0000_01F0; #1;
        n_cmp++; if (HasExp !== 1'b0) begin n_err++; $display("FAIL int_lat0: got %b want 0", HasExp); end
        tick();
        #1;
        n_cmp++; if (HasExp !== 1'b0) begin n_err++; $display("FAIL int_lat1: got %b want 0", HasExp); end
        tick();
        pc = 32'h0000_0200; #1;
        n_cmp++; if (HasExp !== 1'b1) begin n_err++; $display("FAIL int_lat2: got %b want 1", HasExp); end
        tick();
        pc = 32'h0000_0800;
        cp0_sel = 5'd14; #1;
        n_cmp++; if (epc !== 32'h200) begin n_err++; $display("FAIL int_epc: got %h want 200", epc); end
        cp0_sel = 5'd13; #1;
        n_cmp++; if (rdata !== 32'h0000_0400) begin n_err++; $display("FAIL int_cause: got %h want 00000400", rdata); end
        cp0_sel = 5'd12; #1;
        n_cmp++; if (rdata !== 32'h0000_0403) begin n_err++; $display("FAIL int_sr: got %h want 00000403", rdata); end
        n_cmp++; if (HasExp !== 1'b0) begin n_err++; $display("FAIL int_masked0: got %b want 0", HasExp); end
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            n_cmp++; if (HasExp !== 1'b0) begin n_err++; $display("FAIL int_masked_exl: got %b want 0 (cycle %0d)", HasExp, i); end
        end
    endtask

    task automatic test_eret();
        pc = 32'h0000_0300; IsCOP0 = 1'b1; IsEret = 1'b1; #1;
        n_cmp++; if (HasExp !== 1'b0) begin n_err++; $display("FAIL eret_hasexp: got %b want 0", HasExp); end
        tick();
        idle();
        pc = 32'h0000_0200; cp0_sel = 5'd12; #1;
        n_cmp++; if (rdata[1] !== 1'b0) begin n_err++; $display("FAIL eret_exl: got %b want 0", rdata[1]); end
        n_cmp++; if (HasExp !== 1'b1) begin n_err++; $display("FAIL eret_int_taken: got %b want 1", HasExp); end
        tick();
        #1;
        n_cmp++; if (epc !== 32'h200 || rdata[1] !== 1'b1) begin n_err++; $display("FAIL eret_reentry: got epc %h exl %b want 200/1", epc, rdata[1]); end
        hw_int = 6'h0;
        tick(); tick(); tick();
        cp0_sel = 5'd13; #1;
        n_cmp++; if (rdata[15:10] !== 6'h0) begin n_err++; $display("FAIL ip_clear: got %h want 0", rdata[15:10]); end
    endtask

    task automatic test_collision();
        pc = 32'h0000_0100; IsCOP0 = 1'b1; IsEret = 1'b1; IsMtc0 = 1'b1;
        cp0_sel = 5'd14; wdata = 32'hDEAD_BEEF; exc_ov = 1'b1; #1;
        n_cmp++; if (HasExp !== 1'b1) begin n_err++; $display("FAIL coll_hasexp: got %b want 1", HasExp); end
        tick();
        idle();
        cp0_sel = 5'd14; #1;
        n_cmp++; if (rdata !== 32'h100) begin n_err++; $display("FAIL coll_epc: got %h want 100", rdata); end
        cp0_sel = 5'd13; #1;
        n_cmp++; if (rdata[6:2] !== 5'd12) begin n_err++; $display("FAIL coll_code: got %0d want 12", rdata[6:2]); end
        cp0_sel = 5'd12; #1;
        n_cmp++; if (rdata[1] !== 1'b1) begin n_err++; $display("FAIL coll_exl: got %b want 1", rdata[1]); end
        tick();
    endtask

    task automatic test_priority();
        pc = 32'h0000_0180; exc_ri = 1'b1; exc_ov = 1'b1; exc_sys = 1'b1; #1;
        n_cmp++; if (HasExp !== 1'b1) begin n_err++; $display("FAIL prio_hasexp: got %b want 1", HasExp); end
        tick();
        idle();
        cp0_sel = 5'd13; #1;
        n_cmp++; if (rdata !== 32'h0000_0028) begin n_err++; $display("FAIL prio_code: got %h want 00000028", rdata); end
        IsCOP0 = 1'b1; IsMtc0 = 1'b1; wdata = 32'hFFFF_FFFF; #1;
        n_cmp++; if (rdata !== 32'h0000_0028) begin n_err++; $display("FAIL prio_no_bypass: got %h want 00000028", rdata); end
        tick();
        idle();
        cp0_sel = 5'd13; #1;
        n_cmp++; if (rdata !== 32'h0000_0328) begin n_err++; $display("FAIL cause_write: got %h want 00000328", rdata); end
        cp0_sel = 5'd12; #1;
        n_cmp++; if (rdata !== 32'h0000_0403) begin n_err++; $display("FAIL cause_write_sr: got %h want 00000403", rdata); end
        tick();
    endtask

    task automatic test_reset_inflight();
        do_mtc0(5'd13, 32'h0);
        do_mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'h01;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (HasExp !== 1'b0 || epc !== 32'h0) begin n_err++; $display("FAIL inflight_reset: got %b/%h want 0/0", HasExp, epc); end
        @(posedge clk); @(negedge clk);
        m_reset();
        hw_int = 6'h0; rst_n = 1'b1;
        do_mtc0(5'd12, 32'h0000_0401);
        tick();
        #1;
        n_cmp++; if (HasExp !== 1'b0) begin n_err++; $display("FAIL inflight_lost: got %b want 0", HasExp); end
        tick();
        #1;
        n_cmp++; if (HasExp !== 1'b0) begin n_err++; $display("FAIL inflight_lost2: got %b want 0", HasExp); end
    endtask

    task automatic test_random();
        logic        exp_h;
        logic [31:0] exp_r;
        for (int i = 0; i < 600; i++) begin
            pc      = $urandom() & 32'hFFFF_FFFC;
            exc_ri  = ($urandom_range(0, 24) == 0);
            exc_ov  = ($urandom_range(0, 24) == 0);
            exc_sys = ($urandom_range(0, 24) == 0);
            IsCOP0  = ($urandom_range(0, 2) == 0);
            IsMtc0  = ($urandom_range(0, 1) == 0);
            IsEret  = !IsMtc0 && ($urandom_range(0, 2) == 0);
            cp0_sel = 5'($urandom_range(10, 16));
            wdata   = $urandom();
            if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom_range(0, 63));
            #1;
            exp_h = m_has_exp();
            exp_r = m_read(cp0_sel);
            n_cmp++; if (HasExp !== exp_h) begin n_err++; $display("FAIL rnd_hasexp[%0d]: got %b want %b", i, HasExp, exp_h); end
            n_cmp++; if (rdata !== exp_r) begin n_err++; $display("FAIL rnd_rdata[%0d] sel %0d: got %h want %h", i, cp0_sel, rdata, exp_r); end
            n_cmp++; if (epc !== m_epc) begin n_err++; $display("FAIL rnd_epc[%0d]: got %h want %h", i, epc, m_epc); end
            if ($urandom_range(0, 99) == 0) begin
                #1 rst_n = 1'b0;
                #1;
                n_cmp++; if (HasExp !== 1'b0 || epc !== 32'h0) begin n_err++; $display("FAIL rnd_reset[%0d]: got %b/%h want 0/0", i, HasExp, epc); end
                @(posedge clk); @(negedge clk);
                m_reset();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0; pc = '0; cp0_sel = '0; hw_int = '0;
        idle();
        m_reset();
        test_reset();
        test_syscall();
        test_interrupt();
        test_eret();
        test_collision();
        test_priority();
        test_reset_inflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
